// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider.
//   div_op_e    : operation encoding on the op port
//   div_state_e : control FSM states
//   div_ctl_t   : per-operation control latched at acceptance
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  typedef struct packed {
    div_op_e op;
    logic    q_neg;  // operand signs differ: negate quotient
    logic    r_neg;  // dividend negative: negate remainder
  } div_ctl_t;

  // Signed flavours take two's complement operands
  function automatic logic op_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Remainder flavours return the remainder instead of the quotient
  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_xlen_if.sv
// Request/response bundle of the divider.
//   in_valid/in_ready   : request handshake carrying op, dividend, divisor
//   out_valid/out_ready : response handshake carrying result
// master = requester/consumer side, slave = divider side.
interface div_xlen_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, dividend, divisor, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, dividend, divisor, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/div_digit_sel.sv
// Combinational quotient digit selection for one radix-2^RBITS step.
//   rem_i     : partial remainder (XLEN+RBITS bits)
//   dvs_i     : divisor magnitude
//   digit_c_o : largest d with d*dvs_i <= rem_i
//   prod_c_o  : d*dvs_i
module div_digit_sel #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RBITS = 4
) (
  input  logic [XLEN+RBITS-1:0] rem_i,
  input  logic [XLEN-1:0]       dvs_i,
  output logic [RBITS-1:0]      digit_c_o,
  output logic [XLEN+RBITS-1:0] prod_c_o
);

  localparam int unsigned RW = XLEN + RBITS;
  localparam int unsigned ND = 2 ** RBITS;

  // Multiples accumulate by repeated addition; they rise monotonically, so
  // the last one that still fits is the largest legal digit.
  always_comb begin
    logic [RW-1:0] acc;
    digit_c_o = '0;
    prod_c_o  = '0;
    acc       = '0;
    for (int unsigned k = 0; k < ND; k++) begin
      if (acc <= rem_i) begin
        digit_c_o = RBITS'(k);
        prod_c_o  = acc;
      end
      acc = acc + RW'(dvs_i);
    end
  end

endmodule

// File: rtl/div_xlen.sv
// Iterative radix-2^RBITS restoring divider for DIV/DIVU/REM/REMU.
//   clk, rst : clock, synchronous active-high reset
//   flush    : abandon any in-flight operation
//   bus      : request (op, dividend, divisor) and response (result) handshakes
// Latency: N = XLEN/RBITS CALC cycles, one FIXUP cycle, then DONE;
// divide-by-zero and signed overflow go straight to DONE.
module div_xlen
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RBITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  div_xlen_if.slave  bus
);

  localparam int unsigned N  = XLEN / RBITS;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned RW = XLEN + RBITS;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  if (!((XLEN == 32) || (XLEN == 64)) || !((RBITS == 1) || (RBITS == 2) || (RBITS == 4))
      || ((XLEN % RBITS) != 0)) begin : g_bad_param
    $error("div_xlen: unsupported XLEN/RBITS combination");
  end

  div_state_e      state_q, state_d;
  div_ctl_t        ctl_q, ctl_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Request decode: sign handling, magnitudes and the two early-out cases
  div_op_e         op_c;
  logic            accept_c, sgn_c, a_neg_c, b_neg_c, special_c;
  logic [XLEN-1:0] a_abs_c, b_abs_c, special_res_c;

  assign op_c     = div_op_e'(bus.op);
  assign accept_c = bus.in_valid && (state_q == S_IDLE) && !flush;
  assign sgn_c    = op_signed(op_c);
  assign a_neg_c  = sgn_c && bus.dividend[XLEN-1];
  assign b_neg_c  = sgn_c && bus.divisor[XLEN-1];
  assign a_abs_c  = a_neg_c ? (~bus.dividend + XLEN'(1)) : bus.dividend;
  assign b_abs_c  = b_neg_c ? (~bus.divisor + XLEN'(1)) : bus.divisor;

  always_comb begin
    special_c     = 1'b0;
    special_res_c = '0;
    if (bus.divisor == '0) begin
      special_c     = 1'b1;
      special_res_c = op_is_rem(op_c) ? bus.dividend : '1;
    end else if (sgn_c && (bus.dividend == SMIN) && (bus.divisor == '1)) begin
      special_c     = 1'b1;
      special_res_c = op_is_rem(op_c) ? '0 : bus.dividend;
    end
  end

  // Digit selection and trial subtraction for the current step
  logic [RBITS-1:0] digit_c;
  logic [RW-1:0]    prod_c, diff_c;

  div_digit_sel #(
    .XLEN  (XLEN),
    .RBITS (RBITS)
  ) u_digit_sel (
    .rem_i     (rem_q),
    .dvs_i     (dvs_q),
    .digit_c_o (digit_c),
    .prod_c_o  (prod_c)
  );

  assign diff_c = rem_q - prod_c;

  // Final sign correction
  logic [XLEN-1:0] q_fin_c, r_fin_c;

  assign q_fin_c = ctl_q.q_neg ? (~quot_q + XLEN'(1)) : quot_q;
  assign r_fin_c = ctl_q.r_neg ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; flush wins over every handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = special_c ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // FSM outputs, decoded from the registered state
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.result = result_q;

  // Datapath next values
  always_comb begin
    ctl_d    = ctl_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    quot_d   = quot_q;
    result_d = result_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          ctl_d.op    = op_c;
          ctl_d.q_neg = a_neg_c ^ b_neg_c;
          ctl_d.r_neg = a_neg_c;
          dvs_d       = b_abs_c;
          // Top digit seeds the remainder; the rest waits in the shift register
          rem_d       = RW'(a_abs_c[XLEN-1 -: RBITS]);
          dvd_d       = a_abs_c << RBITS;
          quot_d      = '0;
          cnt_d       = CW'(N);
          if (special_c) result_d = special_res_c;
        end
      end
      S_CALC: begin
        // diff_c < divisor, so its upper RBITS bits are zero before the shift
        if (cnt_q == CW'(1)) rem_d = diff_c;
        else                 rem_d = {diff_c[XLEN-1:0], dvd_q[XLEN-1 -: RBITS]};
        dvd_d  = dvd_q << RBITS;
        quot_d = {quot_q[XLEN-RBITS-1:0], digit_c};
        cnt_d  = cnt_q - CW'(1);
      end
      S_FIXUP: begin
        result_d = op_is_rem(ctl_q.op) ? r_fin_c : q_fin_c;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ctl_q    <= ctl_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_div_xlen.sv
// Scoreboard bench for div_xlen: a 32-bit/radix-16 and a 64-bit/radix-4
// instance share one clock; expected results come from plain arithmetic.
module tb_div_xlen;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush32 = 1'b0;
  logic flush64 = 1'b0;
  always #5 clk = ~clk;

  div_xlen_if #(.XLEN(32)) if32 ();
  div_xlen_if #(.XLEN(64)) if64 ();

  div_xlen #(.XLEN(32), .RBITS(4)) u_dut32 (.clk(clk), .rst(rst), .flush(flush32), .bus(if32));
  div_xlen #(.XLEN(64), .RBITS(2)) u_dut64 (.clk(clk), .rst(rst), .flush(flush64), .bus(if64));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: either directed or randomised per cycle
  logic rand_rdy = 1'b0;
  logic rdy32 = 1'b1, rdy64 = 1'b1;
  logic rnd32 = 1'b1, rnd64 = 1'b1;
  assign if32.out_ready = rand_rdy ? rnd32 : rdy32;
  assign if64.out_ready = rand_rdy ? rnd64 : rdy64;
  always @(posedge clk) begin
    #1;
    rnd32 = 1'($urandom_range(0, 1));
    rnd64 = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q32[$];
  exp_t q64[$];

  function automatic logic [63:0] xmask(input bit w64);
    return w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit is_special(input bit w64, input logic [1:0] op,
                                    input logic [63:0] ua, input logic [63:0] ub);
    logic [63:0] smin;
    smin = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    return (ub == 64'd0) ||
           (((op == OP_DIV) || (op == OP_REM)) && (ua == smin) && (ub == xmask(w64)));
  endfunction

  // Reference: language-level signed/unsigned division plus the two corner rules
  function automatic logic [63:0] model(input bit w64, input logic [1:0] op,
                                        input logic [63:0] ua, input logic [63:0] ub);
    logic signed [63:0] sa, sb;
    logic [63:0] r;
    bit rem, sgn;
    rem = (op == OP_REM) || (op == OP_REMU);
    sgn = (op == OP_DIV) || (op == OP_REM);
    sa = w64 ? ua : {{32{ua[31]}}, ua[31:0]};
    sb = w64 ? ub : {{32{ub[31]}}, ub[31:0]};
    if (ub == 64'd0)                     r = rem ? ua : xmask(w64);
    else if (is_special(w64, op, ua, ub)) r = rem ? 64'd0 : ua;
    else if (sgn)                        r = rem ? 64'(sa % sb) : 64'(sa / sb);
    else                                 r = rem ? (ua % ub) : (ua / ub);
    return r & xmask(w64);
  endfunction

  function automatic logic [63:0] gen(input bit w64);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'($urandom_range(1, 15));
      2:       return xmask(w64);
      3:       return w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  // Present one request, wait (bounded) for acceptance, then scramble operands
  task automatic issue(input bit w64, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit push);
    exp_t e;
    logic [63:0] am, bm;
    bit ok;
    am = a & xmask(w64);
    bm = b & xmask(w64);
    e.res = model(w64, op, am, bm);
    e.lat = is_special(w64, op, am, bm) ? 1 : (w64 ? 64 / 2 : 32 / 4) + 2;
    e.acc = 0;
    if (w64) begin
      if64.in_valid = 1'b1; if64.op = op; if64.dividend = am; if64.divisor = bm;
    end else begin
      if32.in_valid = 1'b1; if32.op = op; if32.dividend = am[31:0]; if32.divisor = bm[31:0];
    end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (w64 ? if64.in_ready : if32.in_ready) begin
        ok = 1'b1;
        e.acc = cyc;
        if (push) begin
          if (w64) q64.push_back(e);
          else     q32.push_back(e);
        end
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout w64=%0d op=%0d", w64, op);
    end
    @(posedge clk); #1;
    if (w64) begin
      if64.in_valid = 1'b0; if64.op = 2'($urandom); if64.dividend = {32'($urandom), 32'($urandom)};
      if64.divisor = {32'($urandom), 32'($urandom)};
    end else begin
      if32.in_valid = 1'b0; if32.op = 2'($urandom); if32.dividend = 32'($urandom);
      if32.divisor = 32'($urandom);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: latency on the rising out_valid, result on the handshake
  bit pv32 = 1'b0, pv64 = 1'b0;
  always @(negedge clk) begin
    if (if32.out_valid && !pv32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++; $display("FAIL out32_unexpected result=%h", if32.result);
      end else if (cyc - q32[0].acc != q32[0].lat) begin
        errors++; $display("FAIL lat32 actual=%0d required=%0d", cyc - q32[0].acc, q32[0].lat);
      end
    end
    if (if32.out_valid && if32.out_ready && q32.size() != 0) begin
      checks++;
      if (64'(if32.result) !== q32[0].res) begin
        errors++; $display("FAIL res32 actual=%h required=%h", if32.result, q32[0].res);
      end
      void'(q32.pop_front());
    end
    pv32 = if32.out_valid;
  end

  always @(negedge clk) begin
    if (if64.out_valid && !pv64) begin
      checks++;
      if (q64.size() == 0) begin
        errors++; $display("FAIL out64_unexpected result=%h", if64.result);
      end else if (cyc - q64[0].acc != q64[0].lat) begin
        errors++; $display("FAIL lat64 actual=%0d required=%0d", cyc - q64[0].acc, q64[0].lat);
      end
    end
    if (if64.out_valid && if64.out_ready && q64.size() != 0) begin
      checks++;
      if (if64.result !== q64[0].res) begin
        errors++; $display("FAIL res64 actual=%h required=%h", if64.result, q64[0].res);
      end
      void'(q64.pop_front());
    end
    pv64 = if64.out_valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    if32.in_valid = 1'b0; if32.op = 2'b00; if32.dividend = '0; if32.divisor = '0;
    if64.in_valid = 1'b0; if64.op = 2'b00; if64.dividend = '0; if64.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready32", 64'(if32.in_ready), 64'd1);
    chk("rst_out_valid32", 64'(if32.out_valid), 64'd0);
    chk("rst_result32", 64'(if32.result), 64'd0);
    chk("rst_in_ready64", 64'(if64.in_ready), 64'd1);
    chk("rst_out_valid64", 64'(if64.out_valid), 64'd0);
    chk("rst_result64", if64.result, 64'd0);
    @(posedge clk); #1;

    // Directed cases, including divide-by-zero and signed overflow
    issue(0, OP_DIVU, 64'd100, 64'd7, 1);
    issue(0, OP_REMU, 64'd100, 64'd7, 1);
    issue(0, OP_DIV, 64'hFFFF_FFF9, 64'd2, 1);
    issue(0, OP_REM, 64'hFFFF_FFF9, 64'd2, 1);
    issue(0, OP_DIV, 64'd5, 64'd0, 1);
    issue(0, OP_REM, 64'd5, 64'd0, 1);
    issue(0, OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 1);
    issue(0, OP_REM, 64'h8000_0000, 64'hFFFF_FFFF, 1);
    issue(1, OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1);

    // Consumer stalls five cycles in DONE
    rdy32 = 1'b0;
    issue(0, OP_DIVU, 64'd100, 64'd7, 1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = if32.out_valid;
    end
    chk("stall_reach_done", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_result", 64'(if32.result), 64'd14);
      chk("stall_in_ready", 64'(if32.in_ready), 64'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 rdy32 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_in_ready", 64'(if32.in_ready), 64'd1);
    chk("post_hs_out_valid", 64'(if32.out_valid), 64'd0);
    @(posedge clk); #1;

    // Flush in the third CALC cycle
    issue(0, OP_DIVU, 64'd1000, 64'd3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 flush32 = 1'b1;
    @(posedge clk); #1 flush32 = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 64'(if32.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | if32.out_valid;
      @(negedge clk);
    end
    chk("flush_no_out", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(0, OP_DIVU, 64'd9, 64'd3, 1);

    // Reset in the middle of CALC
    for (int i = 0; i < 60 && q32.size() != 0; i++) @(posedge clk);
    #1;
    issue(0, OP_DIV, 64'd123456, 64'd7, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 64'(if32.in_ready), 64'd1);
    chk("rst_mid_out_valid", 64'(if32.out_valid), 64'd0);
    chk("rst_mid_result", 64'(if32.result), 64'd0);
    @(posedge clk); #1;

    // Randomised traffic with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) issue(0, 2'($urandom), gen(0), gen(0), 1);
    for (int n = 0; n < 40; n++)  issue(1, 2'($urandom), gen(1), gen(1), 1);

    for (int i = 0; i < 5000 && (q32.size() != 0 || q64.size() != 0); i++) @(negedge clk);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain64", 64'(q64.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
